// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch prefetch buffer: CPU-side and ROM-side FSM
// state encodings plus the Avalon OKAY response code.
package ifetch_pkg;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WAIT = 2'd1,
    C_RESP = 2'd2
  } cpu_state_e;

  typedef enum logic [1:0] {
    M_IDLE    = 2'd0,
    M_READ    = 2'd1,
    M_DISCARD = 2'd2
  } mem_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ifetch_fifo.sv
// First-word-fall-through FIFO holding prefetched {err,data} words; clear empties it
// in one cycle and wins over a simultaneous push.
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer between a valid/ready CPU port and an Avalon ROM port.
// Define IFETCH_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module ifetch_prefetch_buffer
  import ifetch_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 4
`ifdef IFETCH_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_valid,
  input  logic [31:0]   cpu_addr,
  output logic          cpu_ready,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_err,
  input  logic          flush,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  input  logic [31:0]   mem_readdata,
  input  logic [1:0]    mem_response,
  input  logic          mem_waitrequest
`ifdef IFETCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_misses
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  cpu_state_e    cst_q;
  mem_state_e    mst_q;
  logic [AW-1:0] head_q, fetch_q, mem_address_q;
  logic          mem_read_q, ready_q, err_q;
  logic [31:0]   rdata_q;

  logic [AW-1:0] req_word;
  logic [32:0]   f_rdata;
  logic [CW-1:0] f_count;
  logic          f_push, f_pop, f_clear, f_empty, f_full;
  logic          req, hit, miss, issue;
  logic          unused_addr;

  assign req_word    = cpu_addr[AW+1:2];
  assign unused_addr = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

  assign f_empty = (f_count == '0);
  assign f_full  = (f_count == CW'(DEPTH));
  // A request arriving together with flush is left for the next cycle.
  assign req     = (cst_q == C_IDLE) && cpu_valid && !flush;
  assign hit     = req && !f_empty && (req_word == head_q);
  assign miss    = req && !hit;
  assign f_clear = flush || miss;
  assign f_push  = (mst_q == M_READ) && !mem_waitrequest && !f_clear;
  assign f_pop   = hit || ((cst_q == C_WAIT) && !f_empty && !flush);
  assign issue   = (mst_q == M_IDLE) && !f_full && !f_clear;

  ifetch_fifo #(.DEPTH(DEPTH), .W(33)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .clear_i (f_clear),
    .wdata_i ({mem_response != RESP_OKAY, mem_readdata}),
    .rdata_o (f_rdata),
    .count_o (f_count)
  );

  // ROM side: one read in flight; an abandoned read is still waited out in M_DISCARD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_q         <= M_IDLE;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      fetch_q       <= '0;
    end else begin
      if (miss)        fetch_q <= req_word;
      else if (f_push) fetch_q <= fetch_q + AW'(1);
      case (mst_q)
        M_IDLE: if (issue) begin
          mst_q         <= M_READ;
          mem_read_q    <= 1'b1;
          mem_address_q <= fetch_q;
        end
        M_READ: if (!mem_waitrequest) begin
          mst_q      <= M_IDLE;
          mem_read_q <= 1'b0;
        end else if (f_clear) begin
          mst_q <= M_DISCARD;
        end
        M_DISCARD: if (!mem_waitrequest) begin
          mst_q      <= M_IDLE;
          mem_read_q <= 1'b0;
        end
        default: mst_q <= M_IDLE;
      endcase
    end
  end

  // CPU side; after a flush the head follows fetch_addr so buffer contents stay contiguous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst_q   <= C_IDLE;
      head_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      if (flush)                head_q <= fetch_q;
      else if (miss)            head_q <= req_word;
      else if (cst_q == C_RESP) head_q <= head_q + AW'(1);
      case (cst_q)
        C_IDLE: if (hit) begin
          cst_q   <= C_RESP;
          ready_q <= 1'b1;
          rdata_q <= f_rdata[31:0];
          err_q   <= f_rdata[32];
        end else if (miss) begin
          cst_q <= C_WAIT;
        end
        C_WAIT: if (flush) begin
          cst_q <= C_IDLE;
        end else if (!f_empty) begin
          cst_q   <= C_RESP;
          ready_q <= 1'b1;
          rdata_q <= f_rdata[31:0];
          err_q   <= f_rdata[32];
        end
        C_RESP:  cst_q <= C_IDLE;
        default: cst_q <= C_IDLE;
      endcase
    end
  end

  assign cpu_ready   = ready_q;
  assign cpu_rdata   = rdata_q;
  assign cpu_err     = err_q;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;

`ifdef IFETCH_STATS_EN
  logic [CNT_W-1:0] hits_q, misses_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (hit)  hits_q   <= sat_inc(hits_q);
      if (miss) misses_q <= sat_inc(misses_q);
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Self-checking bench for ifetch_prefetch_buffer: Avalon ROM slave model, transaction-level
// expectation of every CPU response, directed scenarios then randomized traffic.
module tb_ifetch_prefetch_buffer;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cpu_valid = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic          cpu_err;
  logic          flush = 1'b0;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic [31:0]   mem_readdata = '0;
  logic [1:0]    mem_response = '0;
  logic          mem_waitrequest = 1'b1;
`ifdef IFETCH_STATS_EN
  logic [31:0]   stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  ifetch_prefetch_buffer #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_valid       (cpu_valid),
    .cpu_addr        (cpu_addr),
    .cpu_ready       (cpu_ready),
    .cpu_rdata       (cpu_rdata),
    .cpu_err         (cpu_err),
    .flush           (flush),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_readdata    (mem_readdata),
    .mem_response    (mem_response),
    .mem_waitrequest (mem_waitrequest)
`ifdef IFETCH_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  // Expectation state shared between the stimulus and the checkers
  bit            req_active = 0;
  logic [AW-1:0] req_word   = '0;
  logic [AW-1:0] exp_head   = '0;
  bit            ahead_chk  = 0;
  bit            prev_ready = 0;
  int            resp_cnt   = 0;
  int            err_word   = -1;
  bit            rand_err   = 0;
  bit            rand_wait  = 0;
  bit            rand_flush = 0;
  int            wait_cfg   = 2;
  bit            log_en     = 0;
  logic [AW-1:0] issue_log[$];

  // Slave state
  bit            in_txn = 0;
  int            wcnt = 0;
  int            cur_wait = 0;
  bit            hold = 0;
  logic [AW-1:0] hold_addr = '0;

  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  function automatic logic [1:0] rresp(input logic [AW-1:0] a);
    if (err_word >= 0 && a == AW'(err_word)) return 2'b10;
    if (rand_err && a[2:0] == 3'd5) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response checker: every ready pulse must answer the pending request with ROM contents.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (cpu_ready) begin
        check("ready_has_request", 64'(req_active), 64'd1);
        if (req_active) begin
          check("rdata", 64'(cpu_rdata), 64'(rom(req_word)));
          check("err", 64'(cpu_err), 64'(rresp(req_word) != 2'b00));
          exp_head = req_word + AW'(1);
        end
        check("ready_single_cycle", 64'(prev_ready), 64'd0);
        resp_cnt++;
      end
      prev_ready = cpu_ready;
    end else begin
      prev_ready = 0;
    end
  end

  // Avalon ROM slave with configurable wait states and protocol checks
  always @(negedge clk) begin
    logic [AW-1:0] d;
    if (!rst_n) begin
      in_txn = 0;
      wcnt = 0;
      hold = 0;
      mem_waitrequest = 1'b1;
    end else begin
      if (hold) check("read_held_while_wait", 64'({mem_read, mem_address}), 64'({1'b1, hold_addr}));
      hold = 0;
      if (mem_read) begin
        if (!in_txn) begin
          in_txn = 1;
          wcnt = 0;
          cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
          if (log_en) issue_log.push_back(mem_address);
        end
        if (wcnt >= cur_wait) begin
          mem_waitrequest = 1'b0;
          mem_readdata = rom(mem_address);
          mem_response = rresp(mem_address);
          in_txn = 0;
          if (ahead_chk) begin
            d = mem_address - exp_head;
            check("prefetch_within_depth", 64'(d < AW'(DEPTH)), 64'd1);
          end
        end else begin
          mem_waitrequest = 1'b1;
          wcnt++;
          hold = 1;
          hold_addr = mem_address;
        end
      end else begin
        mem_waitrequest = 1'b1;
        in_txn = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge where ready was observed.
  task automatic fetch(input logic [31:0] addr, input int gap, input int want_lat);
    int n;
    bit got;
    repeat (gap) @(negedge clk);
    cpu_addr   = addr;
    cpu_valid  = 1'b1;
    req_word   = addr[AW+1:2];
    req_active = 1;
    n = 0;
    got = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (cpu_ready) got = 1;
      else if (rand_flush) flush = ($urandom_range(0, 19) == 0);
    end
    flush      = 1'b0;
    cpu_valid  = 1'b0;
    req_active = 0;
    if (!got) check("ready_timeout", 64'd0, 64'd1);
    else if (want_lat > 0) check("valid_to_ready", 64'(n), 64'(want_lat));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cpu_valid = 1'b0;
    flush = 1'b0;
    req_active = 0;
    #1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    int base, n, hi;
    logic [31:0] a32;
    logic [AW-1:0] w;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    check("rst_cpu_err", 64'(cpu_err), 64'd0);
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sequential stream with 2 wait states
    base = resp_cnt;
    fetch(32'h0, 0, 0);
    ahead_chk = 1;
    for (int i = 1; i < 8; i++) fetch(32'(i * 4), 8, 1);
    ahead_chk = 0;
    check("t1_ready_pulses", 64'(resp_cnt - base), 64'd8);
    check("t1_last_word", 64'(cpu_rdata), 64'hA000_0007);

    // Non-sequential jump discards the stream
    do_reset();
    fetch(32'h0, 0, 0);
    fetch(32'h4, 8, 1);
    fetch(32'h100, 0, 0);
    check("t2_jump_data", 64'(cpu_rdata), 64'hA000_0040);
`ifdef IFETCH_STATS_EN
    check("t2_stat_misses", 64'(stat_misses), 64'd2);
    check("t2_stat_hits", 64'(stat_hits), 64'd1);
`endif

    // Flush in the middle of a 5-wait-state read
    do_reset();
    fetch(32'h0, 0, 0);
    fetch(32'h4, 8, 1);
    wait_cfg = 5;
    n = 0;
    hi = 1;
    while (n < 100 && !(mem_read && !hi)) begin
      hi = mem_read;
      @(negedge clk);
      n++;
    end
    check("t3_read_started", 64'(mem_read), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    hi = 1;
    n = 1;
    while (mem_read && n < 20) begin
      @(negedge clk);
      if (mem_read) n++;
    end
    check("t3_read_held_cycles", 64'(n), 64'd5);
    wait_cfg = 2;
    fetch(32'h8, 2, 0);
    check("t3_after_flush_data", 64'(cpu_rdata), 64'hA000_0002);

    // Address wrap at the top of the ROM
    do_reset();
    repeat (2) @(negedge clk);
    issue_log.delete();
    log_en = 1;
    fetch(32'hFF8, 0, 0);
    fetch(32'hFFC, 8, 1);
    fetch(32'h000, 8, 1);
    log_en = 0;
    check("t4_data_wrap", 64'(cpu_rdata), 64'hA000_0000);
    check("t4_log_len_ok", 64'(issue_log.size() >= 3), 64'd1);
    if (issue_log.size() >= 3) begin
      check("t4_addr0", 64'(issue_log[0]), 64'h3FE);
      check("t4_addr1", 64'(issue_log[1]), 64'h3FF);
      check("t4_addr2", 64'(issue_log[2]), 64'h000);
    end

    // Error response on word 3
    do_reset();
    err_word = 3;
    fetch(32'h8, 0, 0);
    check("t5_err_word2", 64'(cpu_err), 64'd0);
    fetch(32'hC, 8, 1);
    check("t5_err_word3", 64'(cpu_err), 64'd1);
    check("t5_data_word3", 64'(cpu_rdata), 64'hA000_0003);
    fetch(32'h10, 8, 1);
    check("t5_err_word4", 64'(cpu_err), 64'd0);
    err_word = -1;

    // Asynchronous reset while a read is outstanding
    n = 0;
    while (!mem_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_read", 64'(mem_read), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_cpu_ready", 64'(cpu_ready), 64'd0);
    check("t6_cpu_err", 64'(cpu_err), 64'd0);
    check("t6_cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("t6_mem_read", 64'(mem_read), 64'd0);
    check("t6_mem_address", 64'(mem_address), 64'd0);
`ifdef IFETCH_STATS_EN
    check("t6_stat_hits", 64'(stat_hits), 64'd0);
    check("t6_stat_misses", 64'(stat_misses), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h0, 0, 0);
    check("t6_restart_data", 64'(cpu_rdata), 64'hA000_0000);

    // Randomized traffic: mostly sequential, some jumps, random stalls, errors and flushes
    do_reset();
    rand_wait  = 1;
    rand_err   = 1;
    rand_flush = 1;
    w = '0;
    for (int i = 0; i < 150; i++) begin
      n = int'($urandom_range(0, 99));
      if (n < 70)      w = w + AW'(1);
      else if (n < 80) w = w;
      else             w = AW'($urandom);
      a32 = $urandom;
      a32[AW+1:2] = w;
      fetch(a32, int'($urandom_range(0, 10)), 0);
    end
    rand_wait  = 0;
    rand_err   = 0;
    rand_flush = 0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
